keypad_entry_encoder: RTL and testbench

// - Producer end of the 3-bit `entry` code consumed by the 7-segment display decoder.
// - Scans 8 raw push-button inputs, synchronises and debounces them, and encodes the

---
 rtl/keypad_entry_encoder_pkg.sv | 30 +++
 rtl/keypad_entry_encoder_if.sv | 19 +
 rtl/keypad_entry_encoder_sync_2ff.sv | 33 +++
 rtl/keypad_entry_encoder.sv | 103 ++++++++++
 tb/tb_keypad_entry_encoder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_encoder_pkg.sv
//------------------------------------------------------------------------------
// keypad_entry_encoder_pkg : shared states, widths and key priority encoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package keypad_entry_encoder_pkg;

  localparam int CODE_W = 3;
  localparam int KEY_N  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // Later set bits overwrite earlier ones, so the highest pressed index wins.
  function automatic logic [CODE_W-1:0] enc_highest(input logic [KEY_N-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_entry_encoder_if.sv
//------------------------------------------------------------------------------
// keypad_entry_encoder_if : raw key inputs and encoded entry outputs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface keypad_entry_encoder_if;
  import keypad_entry_encoder_pkg::*;

  logic [KEY_N-1:0]  keys;
  logic [CODE_W-1:0] entry;
  logic              valid;
  logic              pressed;

  modport master (output keys, input entry, input valid, input pressed);
  modport slave  (input keys, output entry, output valid, output pressed);
endinterface

`default_nettype wire

// File: rtl/keypad_entry_encoder_sync_2ff.sv
//------------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser, parameterised width, async reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  wire logic             clock_i,
  input  wire logic             reset_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

`default_nettype wire

// File: rtl/keypad_entry_encoder.sv
//------------------------------------------------------------------------------
// keypad_entry_encoder : debounced 8-key priority encoder with release lockout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_entry_encoder
  import keypad_entry_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input wire logic               clock_i,
  input wire logic               reset_i,
  keypad_entry_encoder_if.slave  bus_if
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_N-1:0]  w_keys_s;
  logic [CODE_W-1:0] w_enc;
  logic              w_any;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] entry_q, entry_d;
  logic              valid_q, valid_d;

  sync_2ff #(.WIDTH(KEY_N)) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (bus_if.keys),
    .q_o     (w_keys_s)
  );

  assign w_enc = enc_highest(w_keys_s);
  assign w_any = |w_keys_s;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    entry_d = entry_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          cand_d  = w_enc;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // A higher key joining changes the code and forces requalification.
        if (!w_any || (w_enc != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          entry_d = cand_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (w_any) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.entry   = entry_q;
  assign bus_if.valid   = valid_q;
  assign bus_if.pressed = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_encoder.sv
//------------------------------------------------------------------------------
// tb_keypad_entry_encoder : vector table plus directed timing sequences
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_entry_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_entry_encoder_if bus ();

  keypad_entry_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] keys;
    int         hold;
    logic [2:0] exp_code;
    bit         exp_valid;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_entry = 3'd0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every valid pulse must match the oldest expected code and last one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: entry=%0d with no press pending at %0t", bus.entry, $time);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (bus.entry != e) begin
            errors++;
            $display("FAIL valid_entry: got %0d expected %0d at %0t", bus.entry, e, $time);
          end
        end
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_width: got 2+ cycles expected 1 at %0t", $time);
        end
      end
      prev_valid = bus.valid;
    end
  end

  task automatic run_vec(input vec_t v);
    if (v.exp_valid) begin
      exp_q.push_back(v.exp_code);
      exp_entry = v.exp_code;
    end
    bus.keys = v.keys;
    repeat (v.hold) tick();
    bus.keys = 8'h00;
    repeat (2) tick();
    chk("vec_pressed", int'(bus.pressed), int'(v.exp_valid));
    repeat (10) tick();
    chk("vec_released", int'(bus.pressed), 0);
    chk("vec_entry", int'(bus.entry), int'(exp_entry));
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{keys: 8'h20, hold: 20, exp_code: 3'd5, exp_valid: 1'b1};
    vecs[1] = '{keys: 8'h80, hold: 10, exp_code: 3'd7, exp_valid: 1'b1};
    vecs[2] = '{keys: 8'h01, hold: 10, exp_code: 3'd0, exp_valid: 1'b1};
    vecs[3] = '{keys: 8'h0C, hold: 10, exp_code: 3'd3, exp_valid: 1'b1};
    vecs[4] = '{keys: 8'hFF, hold: 8,  exp_code: 3'd7, exp_valid: 1'b1};
    vecs[5] = '{keys: 8'h02, hold: 4,  exp_code: 3'd0, exp_valid: 1'b0};
    vecs[6] = '{keys: 8'h02, hold: 5,  exp_code: 3'd1, exp_valid: 1'b1};
    vecs[7] = '{keys: 8'h50, hold: 12, exp_code: 3'd6, exp_valid: 1'b1};

    bus.keys = 8'h00;
    #2;
    chk("reset_entry", int'(bus.entry), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_pressed", int'(bus.pressed), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Latency from the first sampling edge and release lockout length.
    exp_q.push_back(3'd5);
    exp_entry = 3'd5;
    bus.keys = 8'h20;
    repeat (6) tick();
    chk("lat_before", int'(bus.valid), 0);
    tick();
    chk("lat_valid", int'(bus.valid), 1);
    chk("lat_entry", int'(bus.entry), 5);
    repeat (13) tick();
    bus.keys = 8'h00;
    repeat (5) tick();
    chk("rel_still_pressed", int'(bus.pressed), 1);
    tick();
    chk("rel_dropped", int'(bus.pressed), 0);
    repeat (4) tick();

    // Lower key replacing a held higher key is ignored.
    exp_q.push_back(3'd6);
    exp_entry = 3'd6;
    bus.keys = 8'h44;
    repeat (10) tick();
    bus.keys = 8'h04;
    repeat (10) tick();
    chk("hold_swap_entry", int'(bus.entry), 6);
    chk("hold_swap_pressed", int'(bus.pressed), 1);
    bus.keys = 8'h00;
    repeat (12) tick();

    // Bounce during qualification: timing restarts from the last rising edge.
    exp_q.push_back(3'd1);
    exp_entry = 3'd1;
    bus.keys = 8'h02;
    repeat (2) tick();
    bus.keys = 8'h00;
    tick();
    bus.keys = 8'h02;
    repeat (6) tick();
    chk("bounce_before", int'(bus.valid), 0);
    tick();
    chk("bounce_valid", int'(bus.valid), 1);
    chk("bounce_entry", int'(bus.entry), 1);
    repeat (5) tick();
    bus.keys = 8'h00;
    repeat (12) tick();

    // Reset mid-debounce discards the press and clears outputs immediately.
    bus.keys = 8'h01;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_reset_entry", int'(bus.entry), 0);
    chk("mid_reset_valid", int'(bus.valid), 0);
    chk("mid_reset_pressed", int'(bus.pressed), 0);
    repeat (2) tick();
    rst = 1'b0;
    exp_q.push_back(3'd0);
    exp_entry = 3'd0;
    repeat (12) tick();
    chk("post_reset_pressed", int'(bus.pressed), 1);
    chk("post_reset_entry", int'(bus.entry), 0);
    bus.keys = 8'h00;
    repeat (12) tick();

    // Release bounce in HOLD, then a fresh press.
    exp_q.push_back(3'd3);
    bus.keys = 8'h08;
    repeat (10) tick();
    bus.keys = 8'h00;
    repeat (2) tick();
    bus.keys = 8'h08;
    repeat (2) tick();
    bus.keys = 8'h00;
    repeat (3) tick();
    chk("hold_bounce_pressed", int'(bus.pressed), 1);
    repeat (9) tick();
    chk("hold_bounce_entry", int'(bus.entry), 3);
    exp_q.push_back(3'd7);
    bus.keys = 8'h80;
    repeat (10) tick();
    bus.keys = 8'h00;
    repeat (12) tick();
    chk("final_entry", int'(bus.entry), 7);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
